// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory response block:
// FSM encoding, the word returned on an address error, and the wait-state limit.
package imem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;
  localparam int          WAIT_MAX = 15;

  // Word index of a byte address.
  function automatic logic [29:0] word_of(input logic [31:0] addr);
    return addr[31:2];
  endfunction

endpackage

// File: rtl/imem_array.sv
// Word-wide instruction RAM: one write port, one synchronous read port.
module imem_array #(
  parameter int DEPTH_WORDS = 1024,
  parameter int AW          = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // NOTE: no reset on the storage or the read register; contents survive rst and
  // a reset branch here would stop the array mapping onto a RAM macro.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/imem_resp.sv
// Instruction-fetch responder: one-entry buffer in front of a wait-stated RAM,
// with stall, address-error and loader-write handling.
module imem_resp
  import imem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ice,
  input  logic [31:0] iaddr,
  input  logic        ld_we,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic        stallreq,
  output logic        addr_err
);

  localparam int          AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] DEPTH     = 32'(DEPTH_WORDS);
  localparam logic [3:0]  WAIT_INIT = 4'((WAIT_CYCLES > WAIT_MAX) ? WAIT_MAX : WAIT_CYCLES);

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] req_addr;
  logic [31:0] buf_addr;
  logic [31:0] buf_data;
  logic        buf_valid;
  logic [31:0] rd_data;

  logic legal, hit, ld_in_range, ld_hits_buf, ld_hits_req;
  logic idle_miss, wait_fire, rd_en;
  logic [AW-1:0] rd_addr;
  logic unused_ld_lsbs;

  assign legal       = (iaddr[1:0] == 2'b00) && ({2'b00, word_of(iaddr)} < DEPTH);
  assign hit         = buf_valid && (buf_addr == iaddr);
  assign ld_in_range = {2'b00, word_of(ld_addr)} < DEPTH;
  assign ld_hits_buf = ld_we && (word_of(ld_addr) == word_of(buf_addr));
  assign ld_hits_req = ld_we && (word_of(ld_addr) == word_of(req_addr));

  assign idle_miss = (state == ST_IDLE) && ice && legal && !hit;
  assign wait_fire = (state == ST_WAIT) && ice && (cnt == 4'd1);
  // A loader write owns the array port; the read slips by a cycle.
  assign rd_en     = !ld_we && ((idle_miss && (WAIT_INIT == 4'd0)) || wait_fire);
  assign rd_addr   = (state == ST_WAIT) ? req_addr[AW+1:2] : iaddr[AW+1:2];

  assign unused_ld_lsbs = ^ld_addr[1:0];

  imem_array #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .AW         (AW)
  ) u_array (
    .clk  (clk),
    .we   (ld_we && ld_in_range),
    .waddr(ld_addr[AW+1:2]),
    .wdata(ld_data),
    .re   (rd_en),
    .raddr(rd_addr),
    .rdata(rd_data)
  );

  // NOTE: every output gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    inst       = NOP_WORD;
    inst_valid = 1'b0;
    stallreq   = 1'b0;
    addr_err   = 1'b0;
    if (!rst) begin
      unique case (state)
        ST_IDLE: begin
          if (ice) begin
            if (!legal) begin
              addr_err   = 1'b1;
              inst_valid = 1'b1;
            end else if (hit) begin
              inst_valid = 1'b1;
              inst       = buf_data;
            end else begin
              stallreq = 1'b1;
            end
          end
        end
        ST_WAIT: stallreq = 1'b1;
        ST_RESP: begin
          inst_valid = 1'b1;
          inst       = rd_data;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      req_addr  <= 32'd0;
      buf_addr  <= 32'd0;
      buf_data  <= 32'd0;
      buf_valid <= 1'b0;
    end else begin
      if (ld_hits_buf) buf_valid <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (idle_miss) begin
            req_addr <= iaddr;
            cnt      <= WAIT_INIT;
            if (WAIT_INIT != 4'd0) state <= ST_WAIT;
            else if (!ld_we)       state <= ST_RESP;
          end
        end
        ST_WAIT: begin
          if (!ice) begin
            state <= ST_IDLE;
          end else if (cnt == 4'd1) begin
            if (!ld_we) state <= ST_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          buf_addr  <= req_addr;
          buf_data  <= rd_data;
          // A same-edge loader write to this word makes the captured data stale.
          buf_valid <= !ld_hits_req;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_resp.sv
// Directed bench for imem_resp with DEPTH_WORDS=1024, WAIT_CYCLES=2.
module tb_imem_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        ice;
  logic [31:0] iaddr;
  logic        ld_we;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic [31:0] inst;
  logic        inst_valid;
  logic        stallreq;
  logic        addr_err;

  int n_checks = 0;
  int n_fail   = 0;

  imem_resp #(.DEPTH_WORDS(1024), .WAIT_CYCLES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .ice       (ice),
    .iaddr     (iaddr),
    .ld_we     (ld_we),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .inst      (inst),
    .inst_valid(inst_valid),
    .stallreq  (stallreq),
    .addr_err  (addr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [31:0] i,
                           input logic s, input logic e);
    check({tag, ".inst_valid"}, {31'd0, inst_valid}, {31'd0, v});
    check({tag, ".inst"},       inst,                i);
    check({tag, ".stallreq"},   {31'd0, stallreq},   {31'd0, s});
    check({tag, ".addr_err"},   {31'd0, addr_err},   {31'd0, e});
  endtask

  // Advance past the next rising edge; inputs change here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle before sampling, well clear of the edge.
  task automatic settle();
    #2;
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] d);
    ice = 1'b0; ld_we = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ice = 1'b1; iaddr = 32'h0; ld_we = 1'b0; ld_addr = 32'h0; ld_data = 32'h0;
    settle();
    check_out("reset_outputs", 1'b0, 32'h0, 1'b0, 1'b0);
    tick(); tick();
    rst = 1'b0; ice = 1'b0;

    // Loader fills, with ice low: outputs all zero.
    ld_we = 1'b1; ld_addr = 32'h0; ld_data = 32'h2402_0005;
    settle();
    check_out("idle_ice0", 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    load(32'h4, 32'h1111_2222);

    // First fetch after reset: miss, 3 stall cycles, data in cycle 4.
    ice = 1'b1; iaddr = 32'h0;
    settle(); check_out("miss0_c1", 1'b0, 32'h0, 1'b1, 1'b0);
    tick(); settle(); check_out("miss0_c2", 1'b0, 32'h0, 1'b1, 1'b0);
    tick(); settle(); check_out("miss0_c3", 1'b0, 32'h0, 1'b1, 1'b0);
    tick(); settle(); check_out("miss0_c4", 1'b1, 32'h2402_0005, 1'b0, 1'b0);
    tick();

    // Buffer hit: same cycle, no stall.
    settle(); check_out("hit0", 1'b1, 32'h2402_0005, 1'b0, 1'b0);
    iaddr = 32'h2;
    settle(); check_out("misaligned", 1'b1, 32'h0, 1'b0, 1'b1);
    iaddr = 32'd4096;
    settle(); check_out("out_of_range", 1'b1, 32'h0, 1'b0, 1'b1);
    tick();

    // Loader write to the buffered word invalidates it; iaddr change in WAIT ignored.
    load(32'h0, 32'hFFFF_FFFF);
    ice = 1'b1; iaddr = 32'h0;
    settle(); check_out("inval_c1", 1'b0, 32'h0, 1'b1, 1'b0);
    tick(); iaddr = 32'h4;
    settle(); check_out("inval_c2", 1'b0, 32'h0, 1'b1, 1'b0);
    tick(); settle(); check_out("inval_c3", 1'b0, 32'h0, 1'b1, 1'b0);
    tick(); settle(); check_out("inval_c4", 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    tick();

    // Abort: drop ice in the second WAIT cycle.
    iaddr = 32'h4;
    settle(); check_out("abort_c1", 1'b0, 32'h0, 1'b1, 1'b0);
    tick(); settle(); check_out("abort_c2", 1'b0, 32'h0, 1'b1, 1'b0);
    tick(); ice = 1'b0;
    settle(); check("abort_c3.inst_valid", {31'd0, inst_valid}, 32'd0);
    tick(); settle(); check_out("abort_idle", 1'b0, 32'h0, 1'b0, 1'b0);
    ice = 1'b1; iaddr = 32'h0;
    settle(); check_out("abort_buf_kept", 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);

    // Loader write collides with the array read: one extra stall cycle.
    iaddr = 32'h4;
    settle(); check_out("coll_c1", 1'b0, 32'h0, 1'b1, 1'b0);
    tick(); settle(); check_out("coll_c2", 1'b0, 32'h0, 1'b1, 1'b0);
    tick(); ld_we = 1'b1; ld_addr = 32'h8; ld_data = 32'h3333_4444;
    settle(); check_out("coll_c3", 1'b0, 32'h0, 1'b1, 1'b0);
    tick(); ld_we = 1'b0;
    settle(); check_out("coll_c4", 1'b0, 32'h0, 1'b1, 1'b0);
    tick(); settle(); check_out("coll_c5", 1'b1, 32'h1111_2222, 1'b0, 1'b0);
    tick();

    // Out-of-range write must be dropped, not alias onto word 0.
    load(32'd4096, 32'hDEAD_BEEF);
    ice = 1'b1; iaddr = 32'h0;
    settle(); check("oor_w_c1.stallreq", {31'd0, stallreq}, 32'd1);
    tick(); tick(); tick();
    settle(); check_out("oor_w_resp", 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0);
    tick();

    // Word written during the collision landed.
    iaddr = 32'h8;
    tick(); tick(); tick();
    settle(); check_out("coll_data", 1'b1, 32'h3333_4444, 1'b0, 1'b0);
    tick();

    // Fill 0x4 into the buffer, then reset mid-WAIT.
    iaddr = 32'h4;
    tick(); tick(); tick(); tick();
    settle(); check_out("hit4", 1'b1, 32'h1111_2222, 1'b0, 1'b0);
    iaddr = 32'h0;
    tick(); settle(); check("rst_pre.stallreq", {31'd0, stallreq}, 32'd1);
    rst = 1'b1;
    #1; check_out("rst_in_wait", 1'b0, 32'h0, 1'b0, 1'b0);
    tick(); rst = 1'b0;

    // Buffer cleared by reset: 0x4 is a full-latency miss again.
    iaddr = 32'h4;
    settle(); check_out("post_rst_c1", 1'b0, 32'h0, 1'b1, 1'b0);
    tick(); settle(); check_out("post_rst_c2", 1'b0, 32'h0, 1'b1, 1'b0);
    tick(); settle(); check_out("post_rst_c3", 1'b0, 32'h0, 1'b1, 1'b0);
    tick(); settle(); check_out("post_rst_c4", 1'b1, 32'h1111_2222, 1'b0, 1'b0);
    tick(); ice = 1'b0;
    settle(); check_out("final_idle", 1'b0, 32'h0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_resp.md
IMEM_RESP -- requirements
Module: imem_resp

Interface
REQ-001 Parameter DEPTH_WORDS, default 1024, number of 32-bit instruction words held.
REQ-002 Parameter WAIT_CYCLES, default 2, wait states per array access (legal range 0..15).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 ice  input  1  fetch request valid, from the fetch stage.
REQ-006 iaddr  input  32  byte address of the requested instruction.
REQ-007 ld_we  input  1  loader write enable.
REQ-008 ld_addr  input  32  loader byte address.
REQ-009 ld_data  input  32  loader write data.
REQ-010 inst  output  32  returned instruction word.
REQ-011 inst_valid  output  1  inst is valid this cycle.
REQ-012 stallreq  output  1  hold-PC request; the pipeline drives stall[1] from it.
REQ-013 addr_err  output  1  request is misaligned or out of range.

Function
REQ-014 FSM states are IDLE, WAIT and RESP.
REQ-015 A request is legal when iaddr[1:0]==0 and iaddr[31:2] < DEPTH_WORDS.
REQ-016 Outputs in IDLE are combinational from the inputs, buffer and state.
REQ-017 IDLE, ice=1, illegal request: addr_err=1, inst_valid=1, inst=0, stallreq=0, stay in IDLE.
REQ-018 IDLE, ice=1, legal, hit (buf_valid and buf_addr==iaddr): inst_valid=1, inst=buf_data, stallreq=0, stay in IDLE.
REQ-019 IDLE, ice=1, legal, miss: stallreq=1, inst_valid=0, latch iaddr as req_addr, load cnt=WAIT_CYCLES.
REQ-020 From REQ-019, go to WAIT if WAIT_CYCLES>0; otherwise issue the array read and go to RESP.
REQ-021 In WAIT: stallreq=1 and cnt decrements each cycle.
REQ-022 In WAIT, when cnt==1: issue the synchronous array read at req_addr and go to RESP.
REQ-023 In RESP: inst_valid=1, inst=read data, stallreq=0; load buf_addr/buf_data, set buf_valid, then go to IDLE.
REQ-024 Miss latency is WAIT_CYCLES+2 cycles from request to inst_valid (2 when WAIT_CYCLES=0); a hit has 0 extra cycles.
REQ-025 If ice=0 while in WAIT, abort to IDLE next cycle: no inst_valid, buffer unchanged.
REQ-026 A change of iaddr during WAIT is ignored; the latched req_addr is served.
REQ-027 ld_we=1 writes ld_data at word ld_addr[31:2] if in range; writes out of range are dropped silently.
REQ-028 A loader write to buf_addr clears buf_valid in the same edge.
REQ-029 Loader write and array read in the same cycle: the write wins; the read is deferred one cycle, stallreq stays 1 and the FSM remains in its state.
REQ-030 With ice=0 in IDLE, all outputs are 0.
REQ-031 cnt is 4 bits; it never wraps because it is reloaded only in IDLE.

Reset
REQ-032 rst=1 forces IDLE immediately, including mid-WAIT or mid-RESP.
REQ-033 During reset: inst=0, inst_valid=0, stallreq=0, addr_err=0, cnt=0, buf_valid=0, req_addr=0.
REQ-034 Array contents are not reset.
REQ-035 After rst falls, the first request is handled as a miss.

Structure
REQ-036 Shared package imem_pkg holds the FSM state encoding (2 bits), the NOP word (32'h0) and the WAIT_CYCLES maximum.
REQ-037 Sub-module imem_array is a synchronous-read, single-write-port word RAM of DEPTH_WORDS entries.
REQ-038 The FSM, counter, buffer and error logic stay in imem_resp.

Verification
REQ-039 Loader writes 32'h2402_0005 at 0x0, WAIT_CYCLES=2, ice=1, iaddr=0x0 -> stallreq=1 for 3 cycles, then inst_valid=1 with inst=32'h2402_0005 in cycle 4.
REQ-040 Repeat iaddr=0x0 right after the fill -> inst_valid=1 with the same word and stallreq=0 in the same cycle.
REQ-041 iaddr=0x2 -> addr_err=1, inst=0, stallreq=0; iaddr=DEPTH_WORDS*4 -> addr_err=1.
REQ-042 Loader write 32'hFFFF_FFFF to buffered address 0x0, then fetch 0x0 -> miss path (stallreq=1), returns 32'hFFFF_FFFF.
REQ-043 Drop ice in the second WAIT cycle -> no inst_valid; buffer keeps its prior contents.
REQ-044 Assert rst in WAIT -> outputs 0 immediately and buf_valid=0; the next fetch to 0x4 takes the full miss latency.
